// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer and its 1-bit shift stage.
package shift_pkg;

  typedef enum logic {SH_LOGICAL = 1'b0, SH_ARITH = 1'b1} shift_mode_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t;

  localparam int unsigned DEF_WIDTH = 16;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between a client and the shift sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = shift_pkg::DEF_WIDTH,
  parameter int unsigned AW    = $clog2(WIDTH) + 1
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AW-1:0]    req_amt;
  logic             req_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_data, req_amt, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/shift_sequencer.sv
// Drives an external 1-bit-per-clock right-shift stage for cnt cycles, feeding its
// output back, to build arbitrary shift amounts; result returned on a valid/ready port.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]    sh_in,
  output logic                sh_enable,
  output logic                sh_mode,
  input  logic [WIDTH-1:0]    sh_out,
  output logic                busy
);

  localparam int unsigned SAT_AMT = WIDTH;

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  shift_mode_t      mode_q, mode_d;
  logic             first_q, first_d;
  logic             zero_q, zero_d;

  // State and operation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= SH_LOGICAL;
      first_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and output decode; outputs depend only on state/registers except sh_out feed-through
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    first_d       = first_q;
    zero_d        = zero_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    sh_in         = '0;
    sh_enable     = 1'b0;
    sh_mode       = 1'b0;
    busy          = 1'b1;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          op_d    = bus.req_data;
          mode_d  = bus.req_mode ? SH_ARITH : SH_LOGICAL;
          // Amounts beyond WIDTH give the same result as WIDTH, so saturate the count
          cnt_d   = (bus.req_amt > AW'(SAT_AMT)) ? AW'(SAT_AMT) : bus.req_amt;
          first_d = 1'b1;
          zero_d  = (bus.req_amt == '0);
          state_d = (bus.req_amt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        sh_enable = 1'b1;
        sh_mode   = (mode_q == SH_ARITH);
        sh_in     = first_q ? op_q : sh_out;
        cnt_d     = cnt_q - AW'(1);
        first_d   = 1'b0;
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        bus.rsp_valid = 1'b1;
        // The stage holds its last result while enable is low
        bus.rsp_data  = zero_q ? op_q : sh_out;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with a behavioural 1-bit shift stage.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 5;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sh_in;
  logic [W-1:0] sh_out;
  logic         sh_enable;
  logic         sh_mode;
  logic         busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer_if #(.WIDTH(W), .AW(AW)) bus ();

  shift_sequencer #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sh_in     (sh_in),
    .sh_enable (sh_enable),
    .sh_mode   (sh_mode),
    .sh_out    (sh_out),
    .busy      (busy)
  );

  // Downstream single-bit right-shift stage (no reset, holds when disabled)
  always_ff @(posedge clk) begin
    if (sh_enable) begin
      sh_out <= sh_mode ? {sh_in[W-1], sh_in[W-1:1]} : {1'b0, sh_in[W-1:1]};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request from IDLE (#1 after an edge); returns at the first rsp_valid cycle.
  task automatic run_req(input logic [W-1:0] data, input logic [AW-1:0] amt, input logic mode,
                         output int en_cnt, output int rsp_cyc, output logic [W-1:0] rdata,
                         output int mode_bad, output int overlap, output logic [W-1:0] first_in);
    en_cnt = 0; rsp_cyc = -1; rdata = '0; mode_bad = 0; overlap = 0; first_in = '0;
    bus.req_valid = 1'b1;
    bus.req_data  = data;
    bus.req_amt   = amt;
    bus.req_mode  = mode;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.req_ready && bus.rsp_valid) overlap++;
      if (sh_enable) begin
        en_cnt++;
        if (sh_mode !== mode) mode_bad++;
        if (cyc == 1) first_in = sh_in;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = cyc;
        rdata   = bus.rsp_data;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_amt = '0; bus.req_mode = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    checks++; if (sh_enable !== 1'b0) begin errors++; $display("FAIL reset_sh_enable got %b exp 0", sh_enable); end
    checks++; if (sh_in !== 16'h0000) begin errors++; $display("FAIL reset_sh_in got %h exp 0000", sh_in); end
    checks++; if (sh_mode !== 1'b0) begin errors++; $display("FAIL reset_sh_mode got %b exp 0", sh_mode); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", bus.rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b exp 1/0", bus.req_ready, busy); end
  endtask

  task automatic test_logical();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    run_req(16'h8001, 5'd3, 1'b0, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 3) begin errors++; $display("FAIL logical_enable_cycles got %0d exp 3", en); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL logical_rsp_cycle got %0d exp 4", rc); end
    checks++; if (rd !== 16'h1000) begin errors++; $display("FAIL logical_rsp_data got %h exp 1000", rd); end
    checks++; if (fi !== 16'h8001) begin errors++; $display("FAIL logical_first_sh_in got %h exp 8001", fi); end
    checks++; if (mb !== 0 || ov !== 0) begin errors++; $display("FAIL logical_mode_overlap got mode_bad=%0d overlap=%0d exp 0/0", mb, ov); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL logical_return_idle got valid=%b ready=%b exp 0/1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_arith();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    run_req(16'h8001, 5'd3, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 3) begin errors++; $display("FAIL arith_enable_cycles got %0d exp 3", en); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL arith_rsp_cycle got %0d exp 4", rc); end
    checks++; if (rd !== 16'hF000) begin errors++; $display("FAIL arith_rsp_data got %h exp f000", rd); end
    checks++; if (mb !== 0) begin errors++; $display("FAIL arith_sh_mode got %0d bad cycles exp 0", mb); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_amount();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    run_req(16'h1234, 5'd0, 1'b0, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 0) begin errors++; $display("FAIL zero_enable_cycles got %0d exp 0", en); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL zero_rsp_cycle got %0d exp 1", rc); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL zero_rsp_data got %h exp 1234", rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    run_req(16'h8000, 5'd20, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 16) begin errors++; $display("FAIL sat_arith_enable_cycles got %0d exp 16", en); end
    checks++; if (rc !== 17) begin errors++; $display("FAIL sat_arith_rsp_cycle got %0d exp 17", rc); end
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL sat_arith_rsp_data got %h exp ffff", rd); end
    @(posedge clk); #1;
    run_req(16'h8000, 5'd20, 1'b0, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 16) begin errors++; $display("FAIL sat_logical_enable_cycles got %0d exp 16", en); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL sat_logical_rsp_data got %h exp 0000", rd); end
    @(posedge clk); #1;
    run_req(16'h7FFF, 5'd31, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 16 || rd !== 16'h0000) begin errors++; $display("FAIL sat_max_amt got en=%0d data=%h exp 16/0000", en, rd); end
    @(posedge clk); #1;
    run_req(16'hC3A5, 5'd16, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 16 || rd !== 16'hFFFF) begin errors++; $display("FAIL sat_exact_width got en=%0d data=%h exp 16/ffff", en, rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    bus.rsp_ready = 1'b0;
    run_req(16'h00F0, 5'd4, 1'b0, en, rc, rd, mb, ov, fi);
    checks++; if (rc !== 5 || rd !== 16'h000F) begin errors++; $display("FAIL bp_first_rsp got cyc=%0d data=%h exp 5/000f", rc, rd); end
    bus.req_valid = 1'b1; bus.req_data = 16'hAAAA; bus.req_amt = 5'd1; bus.req_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h000F || bus.req_ready !== 1'b0 ||
          sh_enable !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b en=%b busy=%b exp 1/000f/0/0/1",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready, sh_enable, busy);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0/1/0", bus.rsp_valid, bus.req_ready, busy); end
  endtask

  task automatic test_reset_mid();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    bus.req_valid = 1'b1; bus.req_data = 16'hFF00; bus.req_amt = 5'd8; bus.req_mode = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (sh_enable !== 1'b1) begin errors++; $display("FAIL rstmid_shifting got en=%b exp 1", sh_enable); end
    rst_n = 1'b0;
    #1;
    checks++; if (sh_enable !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got en=%b valid=%b busy=%b exp 0/0/0", sh_enable, bus.rsp_valid, busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got ready=%b valid=%b exp 1/0", bus.req_ready, bus.rsp_valid); end
    run_req(16'h8F0F, 5'd4, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 4 || rc !== 5 || rd !== 16'hF8F0) begin errors++; $display("FAIL rstmid_next_req got en=%0d cyc=%0d data=%h exp 4/5/f8f0", en, rc, rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int en, rc, mb, ov; logic [W-1:0] rd, fi;
    run_req(16'h0F0F, 5'd1, 1'b0, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 1 || rc !== 2 || rd !== 16'h0787) begin errors++; $display("FAIL b2b_first got en=%0d cyc=%0d data=%h exp 1/2/0787", en, rc, rd); end
    @(posedge clk); #1;
    run_req(16'hF00F, 5'd2, 1'b1, en, rc, rd, mb, ov, fi);
    checks++; if (en !== 2 || rc !== 3 || rd !== 16'hFC03) begin errors++; $display("FAIL b2b_second got en=%0d cyc=%0d data=%h exp 2/3/fc03", en, rc, rd); end
    checks++; if (fi !== 16'hF00F) begin errors++; $display("FAIL b2b_second_sh_in got %h exp f00f", fi); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_amount();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
